// File: rtl/dec_1m2s_pkg.sv
// Shared types and decode helper for the one-initiator / two-target MemSplit32 splitter.
package dec_1m2s_pkg;

  typedef logic [0:0] dec_tag_t;

  localparam dec_tag_t SEL_S0 = 1'b0;
  localparam dec_tag_t SEL_S1 = 1'b1;

  function automatic dec_tag_t decode_sel(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] mask);
    return ((addr & mask) == base) ? SEL_S1 : SEL_S0;
  endfunction

endpackage

// File: rtl/dec_1m2s_if.sv
// MemSplit32 bus: split request (req/we/addr/be/wdata -> ack) and response (resp/rdata) channels.
interface dec_1m2s_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic        resp;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input  ack, resp, rdata);
  modport slave  (input  req, we, addr, be, wdata, output ack, resp, rdata);

endinterface

// File: rtl/dec_1m2s_tag_fifo.sv
// Synchronous tag FIFO remembering which target owns each outstanding read, oldest at dout_o.
module dec_1m2s_tag_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  T                 din_i,
  input  logic             pop_i,
  output T                 dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: the storage array is reset too, so a stale tag can never surface at dout_o.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dec_1m2s.sv
// Address decoder: routes one initiator to s0 (default) or s1 (decoded window), returns reads in order.
module dec_1m2s
  import dec_1m2s_pkg::*;
#(
  parameter logic [31:0] S1_BASE  = 32'h8000_0000,
  parameter logic [31:0] S1_MASK  = 32'hF000_0000,
  parameter int          RD_DEPTH = 4
) (
  input logic        clk_i,
  input logic        rst_i,
  dec_1m2s_if.slave  m,
  dec_1m2s_if.master s0,
  dec_1m2s_if.master s1
);

  localparam int CNT_W = $clog2(RD_DEPTH) + 1;

  dec_tag_t         sel;
  dec_tag_t         head_tag;
  dec_tag_t         last_tag_q;
  logic             rd_req;
  logic             stall;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             head_s0;
  logic             head_s1;
  logic             resp_dropped;
  logic [CNT_W-1:0] fifo_count;

  assign sel    = decode_sel(m.addr, S1_BASE, S1_MASK);
  assign rd_req = m.req & ~m.we;
  // A read may only join reads already in flight to the same target, so responses never reorder.
  assign stall  = rd_req & (fifo_full | (~fifo_empty & (sel != last_tag_q)));

  always_comb begin
    // NOTE: defaults first, so every output is assigned on every path and no latch is inferred.
    s0.req = 1'b0; s0.we = 1'b0; s0.addr = '0; s0.be = '0; s0.wdata = '0;
    s1.req = 1'b0; s1.we = 1'b0; s1.addr = '0; s1.be = '0; s1.wdata = '0;
    if (!stall) begin
      if (sel == SEL_S1) begin
        s1.req = m.req; s1.we = m.we; s1.addr = m.addr; s1.be = m.be; s1.wdata = m.wdata;
      end else begin
        s0.req = m.req; s0.we = m.we; s0.addr = m.addr; s0.be = m.be; s0.wdata = m.wdata;
      end
    end
  end

  assign m.ack = ~stall & ((sel == SEL_S1) ? s1.ack : s0.ack);
  assign push  = rd_req & m.ack;

  assign head_s0 = ~fifo_empty & (head_tag == SEL_S0);
  assign head_s1 = ~fifo_empty & (head_tag == SEL_S1);
  assign m.resp  = (head_s0 & s0.resp) | (head_s1 & s1.resp);
  assign m.rdata = (head_s0 & s0.resp) ? s0.rdata :
                   (head_s1 & s1.resp) ? s1.rdata : 32'h0;
  assign pop     = m.resp;

  // Response from a target that does not own the head read; discarded, visible for debug.
  assign resp_dropped = (s0.resp & ~head_s0) | (s1.resp & ~head_s1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)    last_tag_q <= SEL_S0;
    else if (push) last_tag_q <= sel;
  end

  dec_1m2s_tag_fifo #(
    .DEPTH (RD_DEPTH),
    .T     (dec_tag_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .din_i   (sel),
    .pop_i   (pop),
    .dout_o  (head_tag),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  logic unused_ok;
  assign unused_ok = ^{fifo_count, resp_dropped};

endmodule

// File: tb/tb_dec_1m2s.sv
// Directed plus randomized bench for dec_1m2s against a queue-based model of outstanding reads.
module tb_dec_1m2s;

  localparam logic [31:0] S1_BASE  = 32'h8000_0000;
  localparam logic [31:0] S1_MASK  = 32'hF000_0000;
  localparam int          RD_DEPTH = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  dec_1m2s_if m_if ();
  dec_1m2s_if s0_if ();
  dec_1m2s_if s1_if ();

  dec_1m2s #(
    .S1_BASE  (S1_BASE),
    .S1_MASK  (S1_MASK),
    .RD_DEPTH (RD_DEPTH)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .m     (m_if),
    .s0    (s0_if),
    .s1    (s1_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: targets of outstanding reads, oldest first (0 = s0, 1 = s1).
  bit q[$];
  bit exp_push;
  bit exp_pop;
  bit exp_sel;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input logic req, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata);
    m_if.req = req; m_if.we = we; m_if.addr = addr; m_if.be = be; m_if.wdata = wdata;
  endtask

  task automatic set_s(input logic ack0, input logic resp0, input logic [31:0] rdata0,
                       input logic ack1, input logic resp1, input logic [31:0] rdata1);
    s0_if.ack = ack0; s0_if.resp = resp0; s0_if.rdata = rdata0;
    s1_if.ack = ack1; s1_if.resp = resp1; s1_if.rdata = rdata1;
  endtask

  task automatic check_all(input string tag);
    bit          sel, rd, stall, ack, own0, own1, resp, drop;
    logic [31:0] rdata;
    logic [71:0] m_bus, s0_bus, s1_bus;
    sel   = ((m_if.addr & S1_MASK) == S1_BASE);
    rd    = m_if.req && !m_if.we;
    stall = rd && (q.size() == RD_DEPTH || (q.size() != 0 && q[$] != sel));
    ack   = !stall && (sel ? s1_if.ack : s0_if.ack);
    own0  = q.size() != 0 && q[0] == 1'b0;
    own1  = q.size() != 0 && q[0] == 1'b1;
    resp  = (own0 && s0_if.resp) || (own1 && s1_if.resp);
    rdata = (own0 && s0_if.resp) ? s0_if.rdata : (own1 && s1_if.resp) ? s1_if.rdata : 32'h0;
    drop  = (s0_if.resp && !own0) || (s1_if.resp && !own1);
    m_bus  = 72'({m_if.req, m_if.we, m_if.be, m_if.addr, m_if.wdata});
    s0_bus = 72'({s0_if.req, s0_if.we, s0_if.be, s0_if.addr, s0_if.wdata});
    s1_bus = 72'({s1_if.req, s1_if.we, s1_if.be, s1_if.addr, s1_if.wdata});
    chk({tag, ".m_ack"},   72'(m_if.ack),   72'(ack));
    chk({tag, ".m_resp"},  72'(m_if.resp),  72'(resp));
    chk({tag, ".m_rdata"}, 72'(m_if.rdata), 72'(rdata));
    chk({tag, ".s0_bus"},  s0_bus, (!sel && !stall) ? m_bus : 72'h0);
    chk({tag, ".s1_bus"},  s1_bus, ( sel && !stall) ? m_bus : 72'h0);
    chk({tag, ".count"},   72'(dut.u_fifo.count_o), 72'(q.size()));
    chk({tag, ".dropped"}, 72'(dut.resp_dropped), 72'(drop));
    exp_push = rd && ack;
    exp_pop  = resp;
    exp_sel  = sel;
  endtask

  // Inputs are set just after a rising edge; outputs are checked on the falling edge.
  task automatic step(input string tag);
    @(negedge clk_i);
    check_all(tag);
    @(posedge clk_i);
    if (rst_i) begin
      if (exp_pop)  void'(q.pop_front());
      if (exp_push) q.push_back(exp_sel);
    end
    #1;
  endtask

  task automatic idle();
    set_m(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_s(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] addr;
    rst_i = 1'b0;
    idle();
    q.delete();
    step("rst_idle");
    // Reads pass through during reset if the target acks, but nothing is recorded.
    set_m(1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'h0);
    set_s(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step("rst_rd");
    idle();
    rst_i = 1'b1;
    step("rst_rel");

    // 1: write to s0; m.ack follows s0 only.
    set_m(1'b1, 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
    set_s(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step("t1_wr");
    set_s(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step("t1_wr_noack");
    idle();
    step("t1_idle");

    // 2: single read to s1, response two cycles later.
    set_m(1'b1, 1'b0, 32'h8000_0004, 4'hF, 32'h0);
    set_s(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step("t2_rd");
    idle();
    step("t2_wait0");
    step("t2_wait1");
    set_s(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
    step("t2_resp");
    idle();
    step("t2_done");

    // 3: fill the FIFO with s0 reads; a fifth waits for a pop (no same-cycle bypass).
    for (int i = 0; i < RD_DEPTH; i++) begin
      set_m(1'b1, 1'b0, 32'h0000_0100 + 32'(4 * i), 4'hF, 32'h0);
      set_s(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      step($sformatf("t3_rd%0d", i));
    end
    set_m(1'b1, 1'b0, 32'h0000_0110, 4'hF, 32'h0);
    step("t3_full0");
    step("t3_full1");
    set_s(1'b1, 1'b1, 32'h0000_00A0, 1'b0, 1'b0, 32'h0);
    step("t3_pop_nobypass");
    set_s(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step("t3_fifth_acc");
    idle();
    for (int i = 0; i < RD_DEPTH; i++) begin
      set_s(1'b0, 1'b1, 32'h0000_00B0 + 32'(i), 1'b0, 1'b0, 32'h0);
      step($sformatf("t3_resp%0d", i));
    end
    idle();
    step("t3_drained");

    // 4: read to s1 blocked behind an s0 read; writes to s1 still flow.
    set_m(1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'h0);
    set_s(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step("t4_rd_s0");
    set_m(1'b1, 1'b0, 32'h8000_0000, 4'hF, 32'h0);
    set_s(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step("t4_stall");
    set_m(1'b1, 1'b1, 32'h8000_0010, 4'h3, 32'hCAFE_F00D);
    step("t4_wr_s1");
    set_m(1'b1, 1'b0, 32'h8000_0000, 4'hF, 32'h0);
    set_s(1'b0, 1'b1, 32'h0000_0055, 1'b1, 1'b0, 32'h0);
    step("t4_pop");
    set_s(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step("t4_s1_acc");
    idle();
    set_s(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0066);
    step("t4_s1_resp");
    idle();
    step("t4_done");

    // 5: spurious response with nothing outstanding.
    set_s(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0BAD);
    step("t5_spur");
    idle();
    step("t5_done");

    // 6: reset with two reads in flight; the late response is dropped.
    set_m(1'b1, 1'b0, 32'h0000_0300, 4'hF, 32'h0);
    set_s(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step("t6_rd0");
    set_m(1'b1, 1'b0, 32'h0000_0304, 4'hF, 32'h0);
    step("t6_rd1");
    idle();
    rst_i = 1'b0;
    q.delete();
    step("t6_rst");
    rst_i = 1'b1;
    set_s(1'b0, 1'b1, 32'h0000_0077, 1'b0, 1'b0, 32'h0);
    step("t6_late");
    idle();
    step("t6_done");

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      addr = $urandom();
      if ($urandom_range(0, 1) == 1) addr[31:28] = 4'h8;
      set_m($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, addr,
            4'($urandom()), $urandom());
      set_s($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom());
      step($sformatf("rnd%0d", n));
    end
    idle();
    step("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
